// File: rtl/ka_split_sched_93bit_pkg.sv
// Shared constants for the 93-bit GF(2) Karatsuba front end: widths,
// sub-product selectors and scheduler state encoding.
package ka93_defs;

    localparam int N  = 93;
    localparam int HL = 47;
    localparam int HH = N - HL;
    localparam int PW = 2 * HL - 1;

    localparam logic [1:0] SEL_LO  = 2'd0;
    localparam logic [1:0] SEL_HI  = 2'd1;
    localparam logic [1:0] SEL_MID = 2'd2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    // High half zero-extended to the sub-operand width.
    function automatic logic [HL-1:0] hi_ext(input logic [N-1:0] x);
        return {1'b0, x[N-1:HL]};
    endfunction

endpackage

// File: rtl/ka_operand_split_93bit.sv
// Combinational operand selector: picks lo, hi or lo^hi of both operands
// for the requested Karatsuba sub-product.
module ka_operand_split_93bit
    import ka93_defs::*;
(
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic [1:0]    sel,
    output logic [HL-1:0] sub_a,
    output logic [HL-1:0] sub_b
);

    logic [HL-1:0] lo_a, lo_b, hi_a, hi_b;

    assign lo_a = a[HL-1:0];
    assign lo_b = b[HL-1:0];
    assign hi_a = hi_ext(a);
    assign hi_b = hi_ext(b);

    always_comb begin
        sub_a = '0;
        sub_b = '0;
        case (sel)
            SEL_LO: begin
                sub_a = lo_a;
                sub_b = lo_b;
            end
            SEL_HI: begin
                sub_a = hi_a;
                sub_b = hi_b;
            end
            SEL_MID: begin
                sub_a = lo_a ^ hi_a;
                sub_b = lo_b ^ hi_b;
            end
            default: begin
                sub_a = '0;
                sub_b = '0;
            end
        endcase
    end

endmodule

// File: rtl/ka_split_sched_93bit.sv
// Karatsuba front end: issues LO, HI, MID sub-products to a shared
// multiplier, collects the in-order results and presents the product triple.
module ka_split_sched_93bit
    import ka93_defs::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    output logic          sub_valid,
    input  logic          sub_ready,
    output logic [HL-1:0] sub_a,
    output logic [HL-1:0] sub_b,
    output logic [1:0]    sub_sel,
    input  logic          prod_valid,
    input  logic [PW-1:0] prod_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_p_lo,
    output logic [PW-1:0] out_p_mid,
    output logic [PW-1:0] out_p_hi,
    output logic          err
);

    logic [1:0]    state;
    logic [1:0]    iss_cnt;
    logic [1:0]    rcv_cnt;
    logic [N-1:0]  op_a;
    logic [N-1:0]  op_b;
    logic [PW-1:0] p_lo;
    logic [PW-1:0] p_hi;
    logic [PW-1:0] p_mid;

    logic          iss_hs;
    logic [2:0]    iss_eff;
    logic          prod_ok;
    logic [1:0]    sel_cur;
    logic [HL-1:0] split_a;
    logic [HL-1:0] split_b;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign sub_valid = (state == RUN) && (iss_cnt < 2'd3);
    assign iss_hs    = sub_valid && sub_ready;

    // A product is legal only if its request has been (or is being) issued.
    assign iss_eff = {1'b0, iss_cnt} + {2'b00, iss_hs};
    assign prod_ok = (state == RUN) && ({1'b0, rcv_cnt} < iss_eff);

    // Outside an active request the issue bus is parked at zero / LO.
    assign sel_cur = sub_valid ? iss_cnt : SEL_LO;
    assign sub_sel = sel_cur;
    assign sub_a   = sub_valid ? split_a : '0;
    assign sub_b   = sub_valid ? split_b : '0;

    ka_operand_split_93bit u_split (
        .a     (op_a),
        .b     (op_b),
        .sel   (sel_cur),
        .sub_a (split_a),
        .sub_b (split_b)
    );

    assign out_p_lo  = p_lo;
    assign out_p_hi  = p_hi;
    assign out_p_mid = p_mid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            iss_cnt <= 2'd0;
            rcv_cnt <= 2'd0;
            op_a    <= '0;
            op_b    <= '0;
            p_lo    <= '0;
            p_hi    <= '0;
            p_mid   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a    <= in_a;
                        op_b    <= in_b;
                        iss_cnt <= 2'd0;
                        rcv_cnt <= 2'd0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (iss_hs)
                        iss_cnt <= iss_cnt + 2'd1;
                    if (prod_valid && prod_ok) begin
                        rcv_cnt <= rcv_cnt + 2'd1;
                        case (rcv_cnt)
                            2'd0:    p_lo <= prod_data;
                            2'd1:    p_hi <= prod_data;
                            default: begin
                                // Middle term of the Karatsuba recombination.
                                p_mid <= prod_data ^ p_lo ^ p_hi;
                                state <= OUT;
                            end
                        endcase
                    end
                end
                OUT: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else if (prod_valid && !prod_ok)
            err <= 1'b1;
    end

endmodule

// File: tb/tb_ka_split_sched_93bit.sv
// Directed bench for ka_split_sched_93bit with a 3-cycle carry-less
// 47x47 sub-multiplier model and a direct product-injection path.
module tb_ka_split_sched_93bit;
    import ka93_defs::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_a, in_b;
    logic          sub_valid;
    logic          sub_ready = 1'b0;
    logic [HL-1:0] sub_a, sub_b;
    logic [1:0]    sub_sel;
    logic          prod_valid;
    logic [PW-1:0] prod_data;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_p_lo, out_p_mid, out_p_hi;
    logic          err;

    int total = 0;
    int bad   = 0;

    logic rand_rdy, man_rdy, model_en, inj_v;
    logic [PW-1:0] inj_d;

    logic [2:0]    vld_pipe;
    logic [PW-1:0] dpipe [3];

    int            hs_cnt = 0;
    logic [HL-1:0] log_a   [64];
    logic [HL-1:0] log_b   [64];
    logic [1:0]    log_sel [64];

    always #5 clk = ~clk;

    ka_split_sched_93bit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .sub_valid  (sub_valid),
        .sub_ready  (sub_ready),
        .sub_a      (sub_a),
        .sub_b      (sub_b),
        .sub_sel    (sub_sel),
        .prod_valid (prod_valid),
        .prod_data  (prod_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_p_lo   (out_p_lo),
        .out_p_mid  (out_p_mid),
        .out_p_hi   (out_p_hi),
        .err        (err)
    );

    function automatic logic [PW-1:0] clmul47(input logic [HL-1:0] x, input logic [HL-1:0] y);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < HL; i++)
            if (y[i]) r = r ^ ({46'b0, x} << i);
        return r;
    endfunction

    function automatic logic [185:0] clmul93(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [185:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            if (y[i]) r = r ^ ({93'b0, x} << i);
        return r;
    endfunction

    function automatic logic [185:0] combine(input logic [PW-1:0] lo, input logic [PW-1:0] mid,
                                             input logic [PW-1:0] hi);
        return {93'b0, lo} ^ ({93'b0, mid} << 47) ^ ({93'b0, hi} << 94);
    endfunction

    function automatic logic [93:0] ops(input logic [N-1:0] a, input logic [N-1:0] b, input int sel);
        logic [HL-1:0] la, lb, ha, hb;
        la = a[46:0];
        lb = b[46:0];
        ha = {1'b0, a[92:47]};
        hb = {1'b0, b[92:47]};
        if (sel == 0) return {la, lb};
        if (sel == 1) return {ha, hb};
        return {la ^ ha, lb ^ hb};
    endfunction

    // Stand-in sub-multiplier: in-order, 3-cycle latency, reset with the DUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1:0], sub_valid && sub_ready && model_en};
            dpipe[0] <= clmul47(sub_a, sub_b);
            dpipe[1] <= dpipe[0];
            dpipe[2] <= dpipe[1];
        end
    end

    assign prod_valid = vld_pipe[2] | inj_v;
    assign prod_data  = inj_v ? inj_d : dpipe[2];

    always @(posedge clk) begin
        if (rst_n && sub_valid && sub_ready) begin
            log_a[hs_cnt[5:0]]   <= sub_a;
            log_b[hs_cnt[5:0]]   <= sub_b;
            log_sel[hs_cnt[5:0]] <= sub_sel;
            hs_cnt               <= hs_cnt + 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            sub_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : man_rdy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [185:0] obs, input logic [185:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 300) begin
            tick();
            n++;
        end
        chk(tag, out_valid, 1);
    endtask

    task automatic wait_hs(input int target, input string tag);
        int n;
        n = 0;
        while (hs_cnt < target && n < 300) begin
            tick();
            n++;
        end
        chk(tag, hs_cnt, target);
    endtask

    task automatic finish_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [N-1:0]  ta, tb;
    logic [PW-1:0] keep_lo;
    int            s;

    initial begin
        rand_rdy  = 1'b1;
        man_rdy   = 1'b1;
        model_en  = 1'b1;
        inj_v     = 1'b0;
        inj_d     = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;

        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sub_valid", sub_valid, 0);
        chk("rst_sub_ops", {sub_sel, sub_a, sub_b}, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outs", {out_p_lo, out_p_mid, out_p_hi}, 0);
        chk("rst_err", err, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // 1: a=b=1
        s = hs_cnt;
        start_op(93'h1, 93'h1);
        chk("t1_busy", in_ready, 0);
        wait_out("t1_timeout");
        chk("t1_iss0", {log_sel[s],   log_a[s],   log_b[s]},   {2'd0, 47'd1, 47'd1});
        chk("t1_iss1", {log_sel[s+1], log_a[s+1], log_b[s+1]}, {2'd1, 47'd0, 47'd0});
        chk("t1_iss2", {log_sel[s+2], log_a[s+2], log_b[s+2]}, {2'd2, 47'd1, 47'd1});
        chk("t1_lo", out_p_lo, 1);
        chk("t1_mid", out_p_mid, 0);
        chk("t1_hi", out_p_hi, 0);
        finish_out();
        chk("t1_idle", {in_ready, out_valid}, 2'b10);

        // 2: a=b=x^47
        s  = hs_cnt;
        ta = 93'h1 << 47;
        start_op(ta, ta);
        wait_out("t2_timeout");
        chk("t2_iss0", {log_sel[s],   log_a[s],   log_b[s]},   {2'd0, 47'd0, 47'd0});
        chk("t2_iss1", {log_sel[s+1], log_a[s+1], log_b[s+1]}, {2'd1, 47'd1, 47'd1});
        chk("t2_iss2", {log_sel[s+2], log_a[s+2], log_b[s+2]}, {2'd2, 47'd1, 47'd1});
        chk("t2_lo", out_p_lo, 0);
        chk("t2_mid", out_p_mid, 0);
        chk("t2_hi", out_p_hi, 1);
        finish_out();

        // 3: all ones
        s  = hs_cnt;
        ta = '1;
        start_op(ta, ta);
        wait_out("t3_timeout");
        chk("t3_mid_ops", {log_a[s+2], log_b[s+2]}, {47'h4000_0000_0000, 47'h4000_0000_0000});
        chk("t3_mid_raw", out_p_mid ^ out_p_lo ^ out_p_hi, 93'h1 << 92);
        chk("t3_golden", combine(out_p_lo, out_p_mid, out_p_hi), clmul93(ta, ta));
        finish_out();

        // 4: stall during HI issue
        rand_rdy = 1'b0;
        man_rdy  = 1'b1;
        ta = {46'h1234_5678_9ABC, 47'h0765_4321_0FED};
        tb = {46'h0F0F_0F0F_0F0F, 47'h1111_2222_3333};
        s  = hs_cnt;
        start_op(ta, tb);
        wait_hs(s + 1, "t4_lo_hs");
        man_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold", {sub_valid, sub_sel, sub_a, sub_b}, {1'b1, 2'd1, ops(ta, tb, 1)});
        end
        man_rdy = 1'b1;
        wait_out("t4_timeout");
        chk("t4_hs_count", hs_cnt - s, 3);
        chk("t4_golden", combine(out_p_lo, out_p_mid, out_p_hi), clmul93(ta, tb));

        // 5: output backpressure, in_valid ignored
        keep_lo = clmul47(ta[46:0], tb[46:0]);
        s = hs_cnt;
        for (int i = 0; i < 10; i++) begin
            in_a     = 93'h5 + 93'(i);
            in_b     = 93'h3;
            in_valid = i[0];
            tick();
            chk("t5_hold", {in_ready, out_valid, out_p_lo}, {1'b0, 1'b1, keep_lo});
        end
        in_valid = 1'b0;
        chk("t5_golden", combine(out_p_lo, out_p_mid, out_p_hi), clmul93(ta, tb));
        finish_out();
        tick();
        tick();
        chk("t5_no_new_op", {in_ready, out_valid, sub_valid, 32'(hs_cnt - s)}, {3'b100, 32'd0});

        // 6: stray product in IDLE, then reset mid-operation
        inj_d = 93'h1F_FFFF;
        inj_v = 1'b1;
        tick();
        inj_v = 1'b0;
        chk("t6_err", err, 1);
        chk("t6_lo_kept", out_p_lo, keep_lo);
        chk("t6_state", {in_ready, out_valid}, 2'b10);
        s = hs_cnt;
        start_op(ta, tb);
        wait_hs(s + 2, "t6_two_hs");
        rst_n = 1'b0;
        #1;
        chk("t6_rst_outs", {out_p_lo, out_p_mid, out_p_hi}, 0);
        chk("t6_rst_ctl", {in_ready, out_valid, sub_valid, err}, 4'b1000);
        tick();
        #3;
        rst_n = 1'b1;
        #1;
        chk("t6_release", {in_ready, sub_valid}, 2'b10);
        tick();

        // 7: each product returns in the cycle of its own issue
        model_en = 1'b0;
        ta = {46'h2468_ACE0_1357, 47'h5A5A_5A5A_5A5A};
        tb = {46'h0000_0000_0003, 47'h0000_FFFF_0001};
        start_op(ta, tb);
        for (int k = 0; k < 3; k++) begin
            inj_d = clmul47(ops(ta, tb, k)[93:47], ops(ta, tb, k)[46:0]);
            inj_v = 1'b1;
            tick();
        end
        inj_v = 1'b0;
        chk("t7_valid_err", {out_valid, err}, 2'b10);
        chk("t7_golden", combine(out_p_lo, out_p_mid, out_p_hi), clmul93(ta, tb));
        finish_out();

        // 8: product before any issue
        man_rdy = 1'b0;
        tick();
        start_op(ta, tb);
        inj_d = 93'h7;
        inj_v = 1'b1;
        tick();
        inj_v = 1'b0;
        chk("t8_err", err, 1);
        chk("t8_state", {in_ready, out_valid, sub_valid, sub_sel}, {3'b001, 2'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
